// File: rtl/bf16_mul.sv
// bf16_mul: two-stage pipelined BFloat16 multiplier, round-to-nearest-even.
//   clk, rst_n         : clock, async active-low reset
//   in_valid, a, b     : operand stream (no backpressure)
//   out_valid          : result/taps valid, two cycles after in_valid
//   result             : BFloat16 product (subnormals flushed to zero)
//   m_mul/m_nor/m_round: significand product, normalized product, rounded significand
module bf16_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] result,
  output logic [15:0] m_mul,
  output logic [15:0] m_nor,
  output logic [15:0] m_round
);

  localparam int unsigned W  = 16;
  localparam int unsigned EW = 8;
  localparam int unsigned SW = 8;
  localparam int unsigned XW = 10;
  localparam logic signed [XW-1:0] BIAS    = 10'sd127;
  localparam logic signed [XW-1:0] ONE     = 10'sd1;
  localparam logic signed [XW-1:0] EXP_MAX = 10'sd255;
  localparam logic signed [XW-1:0] EXP_MIN = 10'sd0;
  localparam logic [W-1:0]         QNAN    = 16'h7FC0;

  // Stage 1: field decode, significand product, exponent sum, special flags
  logic [EW-1:0]        ea, eb;
  logic [SW-1:0]        sa, sb;
  logic                 a_exp0, b_exp0, a_inf, b_inf, a_nan, b_nan;
  logic [W-1:0]         prod_c;
  logic signed [XW-1:0] esum_c;

  always_comb begin
    ea     = a[14:7];
    eb     = b[14:7];
    a_exp0 = (ea == '0);
    b_exp0 = (eb == '0);
    a_inf  = (ea == '1) && (a[6:0] == '0);
    b_inf  = (eb == '1) && (b[6:0] == '0);
    a_nan  = (ea == '1) && (a[6:0] != '0);
    b_nan  = (eb == '1) && (b[6:0] != '0);
    sa     = {!a_exp0, a[6:0]};
    sb     = {!b_exp0, b[6:0]};
    prod_c = W'(sa) * W'(sb);
    esum_c = $signed(XW'(ea)) + $signed(XW'(eb)) - BIAS;
  end

  logic                 v1, sign1, nan1, inf1, zero1;
  logic [W-1:0]         prod1;
  logic signed [XW-1:0] exp1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      nan1  <= 1'b0;
      inf1  <= 1'b0;
      zero1 <= 1'b0;
      prod1 <= '0;
      exp1  <= '0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        sign1 <= a[15] ^ b[15];
        nan1  <= a_nan || b_nan || (a_inf && b_exp0) || (b_inf && a_exp0);
        inf1  <= a_inf || b_inf;
        zero1 <= a_exp0 || b_exp0;
        prod1 <= prod_c;
        exp1  <= esum_c;
      end
    end
  end

  // Stage 2: normalize, round (RNE), exponent fixup, special-case selection
  logic [W-1:0]         nor_c;
  logic signed [XW-1:0] enor_c, efin_c;
  logic                 guard, sticky, lsb, inc;
  logic [SW:0]          rnd_c;
  logic [SW-1:0]        sig_c;
  logic [W-1:0]         res_c;

  always_comb begin
    nor_c  = prod1[15] ? prod1 : W'(prod1 << 1);
    enor_c = prod1[15] ? exp1 + ONE : exp1;
    guard  = nor_c[7];
    sticky = |nor_c[6:0];
    lsb    = nor_c[8];
    inc    = guard && (sticky || lsb);
    rnd_c  = {1'b0, nor_c[15:8]} + (SW+1)'(inc);
    // Carry out of 0xFF+1 renormalizes to 1.0 with a bumped exponent
    sig_c  = rnd_c[SW] ? 8'h80 : rnd_c[SW-1:0];
    efin_c = rnd_c[SW] ? enor_c + ONE : enor_c;

    res_c = {sign1, efin_c[7:0], sig_c[6:0]};
    if (nan1)                   res_c = QNAN;
    else if (inf1)              res_c = {sign1, 8'hFF, 7'h00};
    else if (zero1)             res_c = {sign1, 15'h0000};
    else if (efin_c >= EXP_MAX) res_c = {sign1, 8'hFF, 7'h00};
    else if (efin_c <= EXP_MIN) res_c = {sign1, 15'h0000};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      m_mul     <= '0;
      m_nor     <= '0;
      m_round   <= '0;
    end else begin
      out_valid <= v1;
      if (v1) begin
        result  <= res_c;
        m_mul   <= prod1;
        m_nor   <= nor_c;
        m_round <= {sig_c, 8'h00};
      end
    end
  end

endmodule

// File: tb/tb_bf16_mul.sv
// Directed testbench for bf16_mul with hand-computed expected values.
module tb_bf16_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_valid;
  logic [15:0] result, m_mul, m_nor, m_round;

  int checks = 0;
  int errors = 0;

  bf16_mul dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .result   (result),
    .m_mul    (m_mul),
    .m_nor    (m_nor),
    .m_round  (m_round)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one operand pair, then a bubble, then check at the following negedge.
  task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic [15:0] exp_res, input logic taps,
                         input logic [15:0] e_mul, input logic [15:0] e_nor,
                         input logic [15:0] e_rnd);
    @(negedge clk);
    a = va; b = vb; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check({tag, ".valid"}, {15'h0, out_valid}, 16'h0001);
    check({tag, ".result"}, result, exp_res);
    if (taps) begin
      check({tag, ".m_mul"}, m_mul, e_mul);
      check({tag, ".m_nor"}, m_nor, e_nor);
      check({tag, ".m_round"}, m_round, e_rnd);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    #1;
    check("rst.valid", {15'h0, out_valid}, 16'h0000);
    check("rst.result", result, 16'h0000);
    check("rst.m_mul", m_mul, 16'h0000);
    check("rst.m_nor", m_nor, 16'h0000);
    check("rst.m_round", m_round, 16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic path
    run_one("mix",  16'h3CCD, 16'hC246, 16'hBF9F, 1'b1, 16'h9E8E, 16'h9E8E, 16'h9F00);
    run_one("m2x3", 16'hC000, 16'h4040, 16'hC0C0, 1'b1, 16'h6000, 16'hC000, 16'hC000);
    run_one("sq15", 16'h3FC0, 16'h3FC0, 16'h4010, 1'b1, 16'h9000, 16'h9000, 16'h9000);
    run_one("h_x4", 16'h3F00, 16'h4080, 16'h4000, 1'b1, 16'h4000, 16'h8000, 16'h8000);
    // Ties: even stays, odd rounds up; carry out of 0xFF renormalizes
    run_one("tie_e", 16'h3F88, 16'h3F88, 16'h3F90, 1'b1, 16'h4840, 16'h9080, 16'h9000);
    run_one("tie_o", 16'h3F88, 16'h3F98, 16'h3FA2, 1'b1, 16'h50C0, 16'hA180, 16'hA200);
    run_one("carry", 16'h3FB5, 16'h3FB5, 16'h4000, 1'b1, 16'h7FF9, 16'hFFF2, 16'h8000);
    // Special cases
    run_one("infx0", 16'h7F80, 16'h0000, 16'h7FC0, 1'b0, '0, '0, '0);
    run_one("nan",   16'h7FC1, 16'h3F80, 16'h7FC0, 1'b0, '0, '0, '0);
    run_one("ninf",  16'hFF80, 16'h4000, 16'hFF80, 1'b0, '0, '0, '0);
    run_one("nzero", 16'h8000, 16'h4040, 16'h8000, 1'b0, '0, '0, '0);
    run_one("ovf",   16'h7F00, 16'h7F00, 16'h7F80, 1'b0, '0, '0, '0);
    run_one("unf",   16'h0100, 16'h0100, 16'h0000, 1'b0, '0, '0, '0);

    // Back-to-back with a bubble: A, B, (bubble), C
    @(negedge clk); a = 16'hC000; b = 16'h4040; in_valid = 1'b1;  // -6.0
    @(negedge clk); a = 16'h3FC0; b = 16'h3FC0; in_valid = 1'b1;  // 2.25
    @(negedge clk); in_valid = 1'b0;
    check("b2b.A.valid", {15'h0, out_valid}, 16'h0001);
    check("b2b.A.result", result, 16'hC0C0);
    @(negedge clk); a = 16'h3F00; b = 16'h4080; in_valid = 1'b1;  // 2.0
    check("b2b.B.valid", {15'h0, out_valid}, 16'h0001);
    check("b2b.B.result", result, 16'h4010);
    @(negedge clk); in_valid = 1'b0;
    check("b2b.bub.valid", {15'h0, out_valid}, 16'h0000);
    check("b2b.bub.hold", result, 16'h4010);
    check("b2b.bub.mmul", m_mul, 16'h9000);
    @(negedge clk);
    check("b2b.C.valid", {15'h0, out_valid}, 16'h0001);
    check("b2b.C.result", result, 16'h4000);

    // Async reset with two operations in flight
    @(negedge clk); a = 16'h3CCD; b = 16'hC246; in_valid = 1'b1;
    @(negedge clk); a = 16'hC000; b = 16'h4040; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst.valid", {15'h0, out_valid}, 16'h0000);
    check("arst.result", result, 16'h0000);
    check("arst.m_mul", m_mul, 16'h0000);
    check("arst.m_nor", m_nor, 16'h0000);
    check("arst.m_round", m_round, 16'h0000);
    @(negedge clk);
    check("arst.hold", result, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_rst.valid%0d", i), {15'h0, out_valid}, 16'h0000);
    end
    check("post_rst.result", result, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_mul.md
Name: bf16_mul

Overview:
- Pipelined BFloat16 (1 sign, 8 exponent bias 127, 7 mantissa) multiplier for the datapath arithmetic units.
- Takes two operands and produces a round-to-nearest-even product two cycles later.
- Also exports three 16-bit debug taps: raw significand product, normalized product and rounded significand.
- Stream interface with valid qualifier; no backpressure.

Parameters:
- None; format fixed to BFloat16.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset
- in_valid  input  1  a/b valid this cycle
- a  input  16  operand A, BFloat16
- b  input  16  operand B, BFloat16
- out_valid  output  1  result/taps valid
- result  output  16  BFloat16 product
- m_mul  output  16  raw 8x8 significand product
- m_nor  output  16  product after normalization
- m_round  output  16  {rounded 8-bit significand, 8'h00}

Interface decisions:
- One clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset: out_valid, result, m_mul, m_nor and m_round all become 0 immediately on rst_n low and stay 0 while it is held.
- Reset mid-operation drops all in-flight operations.
- Latency: exactly 2 cycles from an in_valid=1 sample to out_valid=1. Throughput is 1 per cycle.
- out_valid is a 2-stage delayed copy of in_valid.
- Data registers load only when their stage holds valid data; otherwise they hold their values.
- Stage 1 (registered):
  - sign = a[15]^b[15].
  - Significand sa = {ea!=0, a[6:0]}; sb likewise for b.
  - m_mul = sa*sb, unsigned 16 bits.
  - Exponent sum E = ea+eb-127, 10-bit signed.
  - Special-case flags are captured here.
- Stage 2 (registered):
  - Normalization: if m_mul[15]=1 then m_nor = m_mul and E = E+1; else m_nor = m_mul<<1.
  - Rounding (RNE): keep m_nor[15:8]; guard = m_nor[7]; sticky = |m_nor[6:0]; lsb = m_nor[8].
  - Increment when guard & (sticky | lsb).
  - If the increment carries out (0xFF+1), the significand becomes 0x80 and E = E+1.
  - m_round = {rounded significand, 8'h00}.
- Result fields: result = {sign, E[7:0], rounded significand[6:0]} when 1 <= E <= 254.
- Special cases are checked in priority order:
  1. Either operand is NaN (exp=FF, mant!=0), or inf x zero -> 0x7FC0.
  2. Either operand is inf -> {sign, 8'hFF, 7'h0}.
  3. Either exp=0 (zero or subnormal, flushed) -> {sign, 15'h0}.
  4. Final E >= 255 -> signed inf.
  5. Final E <= 0 -> signed zero.
- Debug taps always show the arithmetic path values, even when a special case overrides result.
- No subnormal outputs are produced.

Test Plan:
- a=0x3CCD (~0.02502), b=0xC246 (-49.5), in_valid=1 -> after 2 cycles: out_valid=1, m_mul=0x9E8E, m_nor=0x9E8E, m_round=0x9F00, result=0xBF9F.
- a=0xC000 (-2.0), b=0x4040 (3.0) -> m_mul=0x6000, m_nor=0xC000, m_round=0xC000, result=0xC0C0 (-6.0).
- a=0x3FC0, b=0x3FC0 (1.5x1.5) -> m_mul=0x9000, result=0x4010 (2.25). a=0x3F00, b=0x4080 (0.5x4) -> result=0x4000.
- Special cases:
  - a=0x7F80 (inf), b=0x0000 -> 0x7FC0.
  - a=0xFF80, b=0x4000 -> 0xFF80.
  - a=0x8000, b=0x4040 -> 0x8000.
  - a=0x7F00, b=0x7F00 (overflow) -> 0x7F80.
  - a=0x0100, b=0x0100 (underflow) -> 0x0000.
- Back-to-back operands on consecutive cycles with one in_valid=0 bubble -> results appear in order, 2 cycles each; out_valid has a matching bubble; outputs hold during the bubble.
- Assert rst_n=0 asynchronously (between clock edges) while two operations are in flight -> outputs zero at once; no stale out_valid after rst_n is released.
